cache_wb_dm: RTL and testbench

- Direct-mapped, write-back, write-allocate cache between one pipelined CPU memory port (instruction or data) and the 16-bit Memory model.
- Serves hits in the same cycle.
- Stalls the CPU via cpu_ready on a miss while it writes back a dirty victim and refills 4-word lines over a req/ack handshake.
- Two instances are used per core: I-side with writes tied low, and D-side.
- Exposes hit/miss counters for the testbench alongside num_inst.

---
 rtl/cache_wb_dm_pkg.sv | 28 ++
 rtl/cache_wb_dm_array.sv | 77 +++++++
 rtl/cache_wb_dm.sv | 169 ++++++++++++++++
 tb/tb_cache_wb_dm.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_wb_dm_pkg.sv
// Shared definitions for the direct-mapped write-back cache: widths,
// address field positions and FSM state encoding.
package cache_wb_dm_pkg;

    localparam int WORD_SIZE  = 16;
    localparam int LINE_WORDS = 4;
    localparam int NUM_SETS   = 4;
    localparam int LINE_BITS  = WORD_SIZE * LINE_WORDS;

    // Word-address fields: offset [1:0], index [3:2], tag [15:4].
    localparam int OFF_LSB = 0;
    localparam int OFF_MSB = 1;
    localparam int IDX_LSB = 2;
    localparam int IDX_MSB = 3;
    localparam int TAG_LSB = 4;
    localparam int TAG_MSB = 15;

    localparam int OFF_W = OFF_MSB - OFF_LSB + 1;
    localparam int IDX_W = IDX_MSB - IDX_LSB + 1;
    localparam int TAG_W = TAG_MSB - TAG_LSB + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_e;

endpackage

// File: rtl/cache_wb_dm_array.sv
// Tag/valid/dirty/data storage with combinational lookup of one set and
// synchronous word-write, line-fill and clean ports (one used per cycle).
module cache_array
    import cache_wb_dm_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [IDX_W-1:0]     idx,
    input  logic [OFF_W-1:0]     off,
    input  logic [TAG_W-1:0]     req_tag,
    output logic                 hit,
    output logic [WORD_SIZE-1:0] rdata,
    output logic                 victim_dirty,
    output logic [TAG_W-1:0]     victim_tag,
    output logic [LINE_BITS-1:0] victim_line,
    input  logic                 word_we,
    input  logic [WORD_SIZE-1:0] word_wdata,
    input  logic                 fill_we,
    input  logic [LINE_BITS-1:0] fill_line,
    input  logic                 clean_we
);

    logic [NUM_SETS-1:0]                valid_q, valid_d;
    logic [NUM_SETS-1:0]                dirty_q, dirty_d;
    logic [NUM_SETS-1:0][TAG_W-1:0]     tag_q, tag_d;
    logic [NUM_SETS-1:0][LINE_BITS-1:0] data_q, data_d;
    logic [5:0]                         word_lsb_s;

    // Lookup of the addressed set; word position is offset * 16.
    always_comb begin
        word_lsb_s   = {off, 4'b0000};
        hit          = valid_q[idx] && (tag_q[idx] == req_tag);
        rdata        = data_q[idx][word_lsb_s +: WORD_SIZE];
        victim_dirty = valid_q[idx] && dirty_q[idx];
        victim_tag   = tag_q[idx];
        victim_line  = data_q[idx];
    end

    // Next contents: the FSM never raises more than one write port at once.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_we) begin
            valid_d[idx] = 1'b1;
            dirty_d[idx] = 1'b0;
            tag_d[idx]   = req_tag;
            data_d[idx]  = fill_line;
        end else if (word_we) begin
            dirty_d[idx] = 1'b1;
            data_d[idx][word_lsb_s +: WORD_SIZE] = word_wdata;
        end else if (clean_we) begin
            dirty_d[idx] = 1'b0;
        end else begin
            data_d = data_q;
        end
    end

    // Valid and dirty bits are cleared on reset, discarding dirty data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tags and data are only meaningful under a valid bit, so no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/cache_wb_dm.sv
// Direct-mapped write-back write-allocate cache: FSM, memory-side
// request registers and hit/miss counters around cache_array.
module cache_wb_dm
    import cache_wb_dm_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cpu_read,
    input  logic                 cpu_write,
    input  logic [WORD_SIZE-1:0] cpu_address,
    input  logic [WORD_SIZE-1:0] cpu_wdata,
    output logic [WORD_SIZE-1:0] cpu_rdata,
    output logic                 cpu_ready,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_address,
    output logic [LINE_BITS-1:0] mem_wdata,
    input  logic [LINE_BITS-1:0] mem_rdata,
    input  logic                 mem_ack,
    output logic [15:0]          hit_count,
    output logic [15:0]          miss_count
);

    state_e                 state_q, state_d;
    logic                   refill_q, refill_d;
    logic [15:0]            hit_cnt_q, hit_cnt_d;
    logic [15:0]            miss_cnt_q, miss_cnt_d;
    logic                   mem_read_q, mem_read_d;
    logic                   mem_write_q, mem_write_d;
    logic [WORD_SIZE-1:0]   mem_addr_q, mem_addr_d;
    logic [LINE_BITS-1:0]   mem_wdata_q, mem_wdata_d;

    logic                   cpu_req_s;
    logic [IDX_W-1:0]       idx_s;
    logic [TAG_W-1:0]       tag_s;
    logic                   hit_s, victim_dirty_s;
    logic [WORD_SIZE-1:0]   rdata_s;
    logic [TAG_W-1:0]       victim_tag_s;
    logic [LINE_BITS-1:0]   victim_line_s;
    logic                   word_we_s, fill_we_s, clean_we_s;

    assign cpu_req_s = cpu_read | cpu_write;
    assign idx_s     = cpu_address[IDX_MSB:IDX_LSB];
    assign tag_s     = cpu_address[TAG_MSB:TAG_LSB];

    cache_array u_array (
        .clk          (clk),
        .reset_n      (reset_n),
        .idx          (idx_s),
        .off          (cpu_address[OFF_MSB:OFF_LSB]),
        .req_tag      (tag_s),
        .hit          (hit_s),
        .rdata        (rdata_s),
        .victim_dirty (victim_dirty_s),
        .victim_tag   (victim_tag_s),
        .victim_line  (victim_line_s),
        .word_we      (word_we_s),
        .word_wdata   (cpu_wdata),
        .fill_we      (fill_we_s),
        .fill_line    (mem_rdata),
        .clean_we     (clean_we_s)
    );

    // FSM next state, array write strobes and counter updates.
    always_comb begin
        state_d    = state_q;
        refill_d   = refill_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        word_we_s  = 1'b0;
        fill_we_s  = 1'b0;
        clean_we_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req_s && hit_s) begin
                    word_we_s = cpu_write;
                    // The replay after a fill is not a first-lookup hit.
                    if (refill_q) begin
                        refill_d = 1'b0;
                    end else begin
                        hit_cnt_d = hit_cnt_q + 16'd1;
                    end
                end else if (cpu_req_s) begin
                    miss_cnt_d = miss_cnt_q + 16'd1;
                    state_d    = victim_dirty_s ? WRITEBACK : FILL;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITEBACK: begin
                if (mem_ack) begin
                    clean_we_s = 1'b1;
                    state_d    = FILL;
                end else begin
                    state_d = WRITEBACK;
                end
            end
            FILL: begin
                if (mem_ack) begin
                    fill_we_s = 1'b1;
                    refill_d  = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = FILL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory-side outputs follow the state being entered so they are registered.
    always_comb begin
        mem_read_d  = (state_d == FILL);
        mem_write_d = (state_d == WRITEBACK);
        mem_wdata_d = (state_d == WRITEBACK) ? victim_line_s : '0;
        case (state_d)
            WRITEBACK: mem_addr_d = {victim_tag_s, idx_s, 2'b00};
            FILL:      mem_addr_d = {tag_s, idx_s, 2'b00};
            default:   mem_addr_d = '0;
        endcase
    end

    // CPU-side response is combinational so hits complete in the same cycle.
    always_comb begin
        if (!reset_n) begin
            cpu_ready = !cpu_req_s;
            cpu_rdata = '0;
        end else if (state_q == IDLE) begin
            cpu_ready = !cpu_req_s || hit_s;
            cpu_rdata = (cpu_read && hit_s) ? rdata_s : '0;
        end else begin
            cpu_ready = 1'b0;
            cpu_rdata = '0;
        end
    end

    // State, refill flag, counters and registered memory outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            refill_q    <= 1'b0;
            hit_cnt_q   <= 16'd0;
            miss_cnt_q  <= 16'd0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            refill_q    <= refill_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign hit_count   = hit_cnt_q;
    assign miss_count  = miss_cnt_q;

endmodule

// File: tb/tb_cache_wb_dm.sv
// Bench for cache_wb_dm: a flat-memory reference model of what the CPU
// must observe, a per-set tag model for hit/miss accounting, and a
// backing memory that answers line requests after a programmable delay.
`timescale 1ns/1ps
module tb_cache_wb_dm;

    logic        clk = 1'b0;
    logic        reset_n, cpu_read, cpu_write, cpu_ready, mem_read, mem_write, mem_ack;
    logic [15:0] cpu_address, cpu_wdata, cpu_rdata, mem_address, hit_count, miss_count;
    logic [63:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    cache_wb_dm dut (
        .clk(clk), .reset_n(reset_n), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_address(cpu_address), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
    );

    logic [15:0] bmem    [0:65535];   // backing memory behind the cache
    logic [15:0] ref_mem [0:65535];   // what the CPU must read back
    logic        m_valid [4];
    logic        m_dirty [4];
    logic [11:0] m_tag   [4];
    logic [15:0] exp_hits, exp_misses;
    int          n_vec, n_fail, ack_delay;
    logic        spurious;
    logic [15:0] last_fill_addr, last_wb_addr, last_rdata;
    logic [63:0] last_wb_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_line(input logic [15:0] base);
        logic [63:0] l;
        for (int w = 0; w < 4; w++) l[16*w +: 16] = ref_mem[base + 16'(w)];
        return l;
    endfunction

    // Reset drops dirty data, so the CPU view of those lines reverts to memory.
    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            if (m_valid[s] === 1'b1 && m_dirty[s] === 1'b1)
                for (int w = 0; w < 4; w++)
                    ref_mem[{m_tag[s], 2'(s), 2'(w)}] = bmem[{m_tag[s], 2'(s), 2'(w)}];
            m_valid[s] = 1'b0;
            m_dirty[s] = 1'b0;
            m_tag[s]   = 12'h000;
        end
        exp_hits   = 16'd0;
        exp_misses = 16'd0;
    endtask

    // Memory model: acks a held request after ack_delay cycles, one-cycle pulse.
    initial begin : responder
        int wait_cnt;
        wait_cnt  = 0;
        mem_ack   = 1'b0;
        mem_rdata = 64'h0;
        forever begin
            @(negedge clk);
            #1;
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (reset_n && (mem_read || mem_write)) begin
                if (wait_cnt >= ack_delay) begin
                    wait_cnt = 0;
                    mem_ack  = 1'b1;
                    for (int w = 0; w < 4; w++) begin
                        if (mem_write) bmem[mem_address + 16'(w)] = mem_wdata[16*w +: 16];
                        else mem_rdata[16*w +: 16] = bmem[mem_address + 16'(w)];
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
                if (spurious) begin
                    mem_ack   = 1'b1;
                    mem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
                    spurious  = 1'b0;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            check("idle_ready", {63'd0, cpu_ready}, 64'd1);
            check("idle_memreq", {62'd0, mem_read, mem_write}, 64'd0);
        end
    endtask

    // One CPU request, checked every cycle until it completes.
    task automatic do_req(input logic wr, input logic [15:0] addr, input logic [15:0] wd);
        logic [1:0]  s;
        logic [11:0] t;
        logic        exp_hit, exp_wb, done, saw_wb, saw_fill;
        logic [15:0] vbase, rbase;
        int          cyc;
        s       = addr[3:2];
        t       = addr[15:4];
        exp_hit = m_valid[s] && (m_tag[s] == t);
        exp_wb  = !exp_hit && m_valid[s] && m_dirty[s];
        vbase   = {m_tag[s], s, 2'b00};
        rbase   = {t, s, 2'b00};
        cpu_write = wr;  cpu_read = !wr;  cpu_address = addr;  cpu_wdata = wd;
        done = 1'b0;  saw_wb = 1'b0;  saw_fill = 1'b0;  cyc = 0;
        #1;
        check("first_lookup_ready", {63'd0, cpu_ready}, {63'd0, exp_hit});
        while (!done) begin
            check("mem_rd_wr_excl", {63'd0, mem_read & mem_write}, 64'd0);
            if (cpu_ready) begin
                if (!wr) begin
                    check("cpu_rdata", {48'd0, cpu_rdata}, {48'd0, ref_mem[addr]});
                    last_rdata = cpu_rdata;
                end
                done = 1'b1;
            end else begin
                if (mem_write) begin
                    check("wb_address", {48'd0, mem_address}, {48'd0, vbase});
                    check("wb_data", mem_wdata, ref_line(vbase));
                    saw_wb = 1'b1;  last_wb_addr = mem_address;  last_wb_data = mem_wdata;
                end
                if (mem_read) begin
                    check("fill_address", {48'd0, mem_address}, {48'd0, rbase});
                    saw_fill = 1'b1;  last_fill_addr = mem_address;
                end
                cyc++;
                if (cyc > 200) begin
                    check("ready_timeout", {63'd0, cpu_ready}, 64'd1);
                    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
                    $finish;
                end
                @(negedge clk);
                #1;
            end
        end
        check("saw_writeback", {63'd0, saw_wb}, {63'd0, exp_wb});
        check("saw_fill", {63'd0, saw_fill}, {63'd0, !exp_hit});
        if (exp_hit) exp_hits++; else exp_misses++;
        if (!exp_hit) begin
            m_valid[s] = 1'b1;  m_tag[s] = t;  m_dirty[s] = 1'b0;
        end
        if (wr) begin
            ref_mem[addr] = wd;  m_dirty[s] = 1'b1;
        end
        @(negedge clk);
        cpu_read = 1'b0;  cpu_write = 1'b0;
        #1;
        check("hit_count", {48'd0, hit_count}, {48'd0, exp_hits});
        check("miss_count", {48'd0, miss_count}, {48'd0, exp_misses});
    endtask

    initial begin : main
        n_vec = 0;  n_fail = 0;  ack_delay = 4;  spurious = 1'b0;
        last_fill_addr = 16'h0;  last_wb_addr = 16'h0;  last_rdata = 16'h0;  last_wb_data = 64'h0;
        for (int a = 0; a < 65536; a++) begin
            bmem[a]    = 16'(a) ^ 16'hC3C3;
            ref_mem[a] = bmem[a];
        end
        for (int s = 0; s < 4; s++) begin
            m_valid[s] = 1'b0;  m_dirty[s] = 1'b0;  m_tag[s] = 12'h000;
        end
        model_reset();
        reset_n = 1'b0;  cpu_read = 1'b0;  cpu_write = 1'b0;  cpu_address = 16'h0;  cpu_wdata = 16'h0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_cpu_ready", {63'd0, cpu_ready}, 64'd1);
        check("rst_mem_read", {63'd0, mem_read}, 64'd0);
        check("rst_mem_write", {63'd0, mem_write}, 64'd0);
        check("rst_mem_address", {48'd0, mem_address}, 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        check("rst_cpu_rdata", {48'd0, cpu_rdata}, 64'd0);
        check("rst_hit_count", {48'd0, hit_count}, 64'd0);
        check("rst_miss_count", {48'd0, miss_count}, 64'd0);

        // Cold read: fill of 0x0010, word0 = 0x0010 ^ 0xC3C3.
        do_req(1'b0, 16'h0010, 16'h0);
        check("cold_fill_addr", {48'd0, last_fill_addr}, 64'h0010);
        check("cold_rdata", {48'd0, last_rdata}, 64'hC3D3);
        check("cold_miss_count", {48'd0, miss_count}, 64'd1);
        check("cold_hit_count", {48'd0, hit_count}, 64'd0);

        // Hits on words 1 and 3 of the filled line.
        do_req(1'b0, 16'h0011, 16'h0);
        check("hit_w1_rdata", {48'd0, last_rdata}, 64'hC3D2);
        do_req(1'b0, 16'h0013, 16'h0);
        check("hit_w3_rdata", {48'd0, last_rdata}, 64'hC3D0);
        check("hits_two", {48'd0, hit_count}, 64'd2);

        // Dirty the line, then evict it with a conflicting tag.
        do_req(1'b1, 16'h0012, 16'h1234);
        do_req(1'b0, 16'h0050, 16'h0);
        check("evict_wb_addr", {48'd0, last_wb_addr}, 64'h0010);
        check("evict_wb_word2", {48'd0, last_wb_data[47:32]}, 64'h1234);
        check("evict_fill_addr", {48'd0, last_fill_addr}, 64'h0050);
        check("evict_miss_count", {48'd0, miss_count}, 64'd2);

        // Write miss on a clean set: allocate, merge, and later write back.
        do_req(1'b1, 16'h0024, 16'hBEEF);
        check("wmiss_fill_addr", {48'd0, last_fill_addr}, 64'h0024);
        do_req(1'b0, 16'h0024, 16'h0);
        check("wmiss_readback", {48'd0, last_rdata}, 64'hBEEF);
        do_req(1'b0, 16'h0064, 16'h0);
        check("wmiss_wb_addr", {48'd0, last_wb_addr}, 64'h0024);
        check("wmiss_wb_word0", {48'd0, last_wb_data[15:0]}, 64'hBEEF);
        check("wmiss_wb_word1", {48'd0, last_wb_data[31:16]}, 64'hC3E6);

        // Reset while a fill is outstanding.
        @(negedge clk);
        cpu_read = 1'b1;  cpu_address = 16'h0084;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_read) break;
        end
        check("fill_before_reset", {63'd0, mem_read}, 64'd1);
        reset_n = 1'b0;  cpu_read = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        model_reset();
        check("abort_mem_read", {63'd0, mem_read}, 64'd0);
        check("abort_cpu_ready", {63'd0, cpu_ready}, 64'd1);
        check("abort_hit_count", {48'd0, hit_count}, 64'd0);
        check("abort_miss_count", {48'd0, miss_count}, 64'd0);
        do_req(1'b0, 16'h0084, 16'h0);
        check("reread_misses", {48'd0, miss_count}, 64'd1);

        // A stray ack while idle must change nothing.
        spurious = 1'b1;
        idle(4);
        check("spur_hit_count", {48'd0, hit_count}, 64'd0);
        check("spur_miss_count", {48'd0, miss_count}, 64'd1);
        do_req(1'b0, 16'h0084, 16'h0);
        check("spur_rdata", {48'd0, last_rdata}, 64'hC347);
        check("spur_then_hit", {48'd0, hit_count}, 64'd1);

        // Randomized traffic over a small address footprint.
        for (int n = 0; n < 300; n++) begin
            logic [15:0] a;
            ack_delay = int'($urandom_range(0, 5));
            a = 16'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a[15:12] = 4'hF;
            if ($urandom_range(0, 9) < 4) do_req(1'b1, a, 16'($urandom));
            else do_req(1'b0, a, 16'h0);
            if ($urandom_range(0, 9) == 0) idle(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
